// File: rtl/rope_toggle_gen.sv
// Rope direction-toggle generator: requests a direction reversal once per frame when the rope
// overlaps a boundary or reaches a position limit, then ignores hits for a few frames.
module rope_toggle_gen #(
    parameter int LEFT_LIMIT      = 32,
    parameter int RIGHT_LIMIT     = 608,
    parameter int ROPE_WIDTH      = 16,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               ropeDrawingRequest,
    input  logic               boundaryDrawingRequest,
    input  logic signed [10:0] topLeftX,
    output logic               dirToggle,
    output logic               movingRight,
    output logic [7:0]         toggleCount,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic signed [11:0] LEFT_S  = 12'(LEFT_LIMIT);
    localparam logic signed [11:0] RIGHT_S = 12'(RIGHT_LIMIT);
    localparam logic signed [11:0] WIDTH_S = 12'(ROPE_WIDTH);
    localparam logic [3:0]         CD_INIT = 4'(COOLDOWN_FRAMES);

    state_t      state_q, state_d;
    logic        hit_q, hit_d;
    logic [3:0]  cd_q, cd_d;
    logic        dir_q, dir_d;
    logic        mr_q, mr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic signed [11:0] x_ext;
    logic signed [11:0] right_edge;
    logic               pos_hit;

    // Sign-extend to 12 bits so negative positions count as past the left limit.
    always_comb begin
        x_ext      = {topLeftX[10], topLeftX};
        right_edge = x_ext + WIDTH_S;
        pos_hit    = (mr_q && (right_edge >= RIGHT_S)) || (!mr_q && (x_ext <= LEFT_S));
    end

    // Overlap seen in the frame-start cycle itself belongs to no frame and is dropped.
    always_comb begin
        hit_d = startOfFrame ? 1'b0 : (hit_q | (ropeDrawingRequest & boundaryDrawingRequest));
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        dir_d   = 1'b0;
        mr_d    = mr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARMED: begin
                if (startOfFrame && (hit_q || pos_hit)) begin
                    state_d = FIRE;
                    dir_d   = 1'b1;
                    mr_d    = !mr_q;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            FIRE: begin
                if (CD_INIT == 4'd0) begin
                    state_d = ARMED;
                end else begin
                    state_d = COOLDOWN;
                    cd_d    = CD_INIT;
                end
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    cd_d = (cd_q == 4'd0) ? 4'd0 : cd_q - 4'd1;
                    if (cd_q <= 4'd1) begin
                        state_d = ARMED;
                    end
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ARMED;
            hit_q   <= 1'b0;
            cd_q    <= 4'd0;
            dir_q   <= 1'b0;
            mr_q    <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            cd_q    <= cd_d;
            dir_q   <= dir_d;
            mr_q    <= mr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dirToggle   = dir_q;
    assign movingRight = mr_q;
    assign toggleCount = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_rope_toggle_gen.sv
// Bench for rope_toggle_gen: directed scenarios plus randomized frames, all checked against
// a frame-level reference model of the toggle rules.
module tb_rope_toggle_gen;
  localparam int COOLDOWN = 4;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              ropeDrawingRequest;
  logic              boundaryDrawingRequest;
  logic signed [10:0] topLeftX;
  logic              dirToggle;
  logic              movingRight;
  logic [7:0]        toggleCount;
  logic [1:0]        state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m_mr;
  int m_cnt;
  int m_cd;
  bit m_latch;
  bit m_toggle;

  always #5 clk = ~clk;

  rope_toggle_gen dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .ropeDrawingRequest(ropeDrawingRequest),
    .boundaryDrawingRequest(boundaryDrawingRequest),
    .topLeftX(topLeftX),
    .dirToggle(dirToggle),
    .movingRight(movingRight),
    .toggleCount(toggleCount),
    .state_dbg(state_dbg)
  );

  function automatic bit ref_pos_hit(input int x, input bit mr);
    return (mr && (x + 16 >= 608)) || (!mr && (x <= 32));
  endfunction

  task automatic model_reset();
    m_mr = 1'b1;
    m_cnt = 0;
    m_cd = 0;
    m_latch = 1'b0;
    m_toggle = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, return at the next falling edge.
  task automatic step(input bit sof, input bit rope, input bit bnd, input int x);
    startOfFrame = sof;
    ropeDrawingRequest = rope;
    boundaryDrawingRequest = bnd;
    topLeftX = 11'(x);
    @(posedge clk);
    m_toggle = 1'b0;
    if (sof) begin
      if (m_cd > 0) begin
        m_cd--;
      end else if (m_latch || ref_pos_hit(x, m_mr)) begin
        m_toggle = 1'b1;
        m_mr = !m_mr;
        if (m_cnt < 255) m_cnt++;
        m_cd = COOLDOWN;
      end
      m_latch = 1'b0;
    end else if (rope && bnd) begin
      m_latch = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    startOfFrame = 1'b0;
    ropeDrawingRequest = 1'b0;
    boundaryDrawingRequest = 1'b0;
    topLeftX = 11'sd280;
    repeat (2) @(negedge clk);
    model_reset();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    int pulses;
    do_reset();
    n_cmp++;
    if (dirToggle !== 1'b0) begin n_err++; $display("FAIL reset_dir: got %0b want 0", dirToggle); end
    n_cmp++;
    if (movingRight !== 1'b1) begin n_err++; $display("FAIL reset_mr: got %0b want 1", movingRight); end
    n_cmp++;
    if (toggleCount !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", toggleCount); end
    pulses = 0;
    for (int f = 0; f < 10; f++) begin
      step(1, 0, 0, 280);
      if (dirToggle === 1'b1) pulses++;
      for (int c = 0; c < 3; c++) begin
        step(0, 0, 0, 280);
        if (dirToggle === 1'b1) pulses++;
      end
    end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    n_cmp++;
    if (movingRight !== 1'b1) begin n_err++; $display("FAIL idle_mr: got %0b want 1", movingRight); end
    n_cmp++;
    if (toggleCount !== 8'd0) begin n_err++; $display("FAIL idle_cnt: got %0d want 0", toggleCount); end
  endtask

  task automatic test_right_limit();
    do_reset();
    step(0, 0, 0, 592);
    n_cmp++;
    if (dirToggle !== 1'b0) begin n_err++; $display("FAIL right_early: got %0b want 0", dirToggle); end
    step(1, 0, 0, 592);
    n_cmp++;
    if (dirToggle !== 1'b1) begin n_err++; $display("FAIL right_pulse: got %0b want 1", dirToggle); end
    n_cmp++;
    if (movingRight !== 1'b0) begin n_err++; $display("FAIL right_mr: got %0b want 0", movingRight); end
    n_cmp++;
    if (toggleCount !== 8'd1) begin n_err++; $display("FAIL right_cnt: got %0d want 1", toggleCount); end
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 592);
      n_cmp++;
      if (dirToggle !== 1'b0) begin n_err++; $display("FAIL right_after: cycle %0d got %0b want 0", c, dirToggle); end
    end
  endtask

  task automatic test_overlap_cooldown();
    int pulses;
    do_reset();
    step(0, 0, 0, 280);
    repeat (3) step(0, 1, 1, 280);
    step(0, 0, 0, 280);
    step(1, 0, 0, 280);
    n_cmp++;
    if (dirToggle !== 1'b1) begin n_err++; $display("FAIL ovl_first: got %0b want 1", dirToggle); end
    pulses = 0;
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 3; c++) begin
        step(0, 1, 1, 280);
        if (dirToggle === 1'b1) pulses++;
      end
      step(1, 0, 0, 280);
      if (dirToggle === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL ovl_cooldown: got %0d pulses want 0", pulses); end
    repeat (3) step(0, 1, 1, 280);
    step(1, 0, 0, 280);
    n_cmp++;
    if (dirToggle !== m_toggle || m_toggle !== 1'b1) begin
      n_err++; $display("FAIL ovl_second: got %0b want 1", dirToggle);
    end
    step(0, 0, 0, 280);
    n_cmp++;
    if (dirToggle !== 1'b0) begin n_err++; $display("FAIL ovl_second_end: got %0b want 0", dirToggle); end
    n_cmp++;
    if (toggleCount !== 8'd2) begin n_err++; $display("FAIL ovl_cnt: got %0d want 2", toggleCount); end
  endtask

  task automatic test_sof_overlap();
    int pulses;
    do_reset();
    pulses = 0;
    step(0, 0, 0, 280);
    step(0, 0, 0, 280);
    step(1, 1, 1, 280);
    if (dirToggle === 1'b1) pulses++;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 280);
      if (dirToggle === 1'b1) pulses++;
    end
    step(1, 0, 0, 280);
    if (dirToggle === 1'b1) pulses++;
    step(0, 0, 0, 280);
    if (dirToggle === 1'b1) pulses++;
    n_cmp++;
    if (pulses != 0) begin n_err++; $display("FAIL sof_overlap: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_negative_x();
    do_reset();
    step(0, 0, 0, 592);
    step(1, 0, 0, 592);
    for (int f = 0; f < 4; f++) begin
      step(0, 0, 0, 280);
      step(1, 0, 0, 280);
    end
    step(0, 0, 0, -5);
    step(1, 0, 0, -5);
    n_cmp++;
    if (dirToggle !== 1'b1) begin n_err++; $display("FAIL neg_left_pulse: got %0b want 1", dirToggle); end
    n_cmp++;
    if (movingRight !== 1'b1) begin n_err++; $display("FAIL neg_left_mr: got %0b want 1", movingRight); end
    for (int f = 0; f < 4; f++) begin
      step(0, 0, 0, -5);
      step(1, 0, 0, -5);
    end
    step(0, 0, 0, -5);
    step(1, 0, 0, -5);
    n_cmp++;
    if (dirToggle !== 1'b0) begin n_err++; $display("FAIL neg_right_pulse: got %0b want 0", dirToggle); end
    n_cmp++;
    if (movingRight !== 1'b1) begin n_err++; $display("FAIL neg_right_mr: got %0b want 1", movingRight); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 0, 0, 592);
    step(0, 0, 0, 280);
    for (int f = 0; f < 4; f++) begin
      step(1, 0, 0, 280);
      n_cmp++;
      if (dirToggle !== 1'b0) begin n_err++; $display("FAIL b2b_cool: sof %0d got %0b want 0", f, dirToggle); end
    end
    step(1, 0, 0, -5);
    n_cmp++;
    if (dirToggle !== 1'b1) begin n_err++; $display("FAIL b2b_fire: got %0b want 1", dirToggle); end
    step(0, 0, 0, 280);
    n_cmp++;
    if (movingRight !== 1'b1 || toggleCount !== 8'd2) begin
      n_err++; $display("FAIL b2b_state: got mr=%0b cnt=%0d want mr=1 cnt=2", movingRight, toggleCount);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    do_reset();
    step(1, 0, 0, 592);
    #1 resetN = 1'b0;
    #1;
    n_cmp++;
    if (dirToggle !== 1'b0) begin n_err++; $display("FAIL abort_fire_dir: got %0b want 0", dirToggle); end
    n_cmp++;
    if (toggleCount !== 8'd0) begin n_err++; $display("FAIL abort_fire_cnt: got %0d want 0", toggleCount); end
    @(negedge clk);
    model_reset();
    resetN = 1'b1;
    step(1, 0, 0, 592);
    step(0, 0, 0, 280);
    step(1, 0, 0, 280);
    @(posedge clk);
    #1 resetN = 1'b0;
    @(negedge clk);
    model_reset();
    resetN = 1'b1;
    pulses = 0;
    step(0, 1, 1, 280);
    if (dirToggle === 1'b1) pulses++;
    step(1, 0, 0, 280);
    n_cmp++;
    if (pulses != 0 || dirToggle !== 1'b1) begin
      n_err++; $display("FAIL abort_cool_resume: got pre=%0d dir=%0b want pre=0 dir=1", pulses, dirToggle);
    end
    n_cmp++;
    if (toggleCount !== 8'd1) begin n_err++; $display("FAIL abort_cool_cnt: got %0d want 1", toggleCount); end
  endtask

  task automatic test_saturation();
    int pulses;
    int bad;
    do_reset();
    pulses = 0;
    bad = 0;
    for (int f = 0; f < 1500; f++) begin
      step(1, 0, 0, 280);
      if (dirToggle === 1'b1) pulses++;
      if (dirToggle !== m_toggle || toggleCount !== 8'(m_cnt)) bad++;
      step(0, 1, 1, 280);
      if (dirToggle !== m_toggle || toggleCount !== 8'(m_cnt)) bad++;
    end
    n_cmp++;
    if (pulses != 300) begin n_err++; $display("FAIL sat_pulses: got %0d want 300", pulses); end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL sat_track: got %0d bad cycles want 0", bad); end
    n_cmp++;
    if (toggleCount !== 8'd255) begin n_err++; $display("FAIL sat_cnt: got %0d want 255", toggleCount); end
  endtask

  task automatic test_random();
    int xs[11] = '{-1024, -5, 0, 31, 32, 33, 280, 591, 592, 593, 1000};
    int len;
    int x;
    bit rope;
    bit bnd;
    int bad_shown;
    do_reset();
    bad_shown = 0;
    for (int f = 0; f < 400; f++) begin
      len = $urandom_range(2, 6);
      x = xs[$urandom_range(0, 10)];
      for (int c = 0; c < len; c++) begin
        rope = ($urandom_range(0, 3) == 0);
        bnd = ($urandom_range(0, 2) == 0);
        step(c == 0, rope, bnd, x);
        n_cmp++;
        if (dirToggle !== m_toggle || movingRight !== m_mr || toggleCount !== 8'(m_cnt)) begin
          n_err++;
          if (bad_shown < 10) begin
            bad_shown++;
            $display("FAIL rand_frame%0d_c%0d: got dir=%0b mr=%0b cnt=%0d want dir=%0b mr=%0b cnt=%0d",
                     f, c, dirToggle, movingRight, toggleCount, m_toggle, m_mr, m_cnt);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    ropeDrawingRequest = 1'b0;
    boundaryDrawingRequest = 1'b0;
    topLeftX = 11'sd280;
    @(negedge clk);
    test_reset();
    test_right_limit();
    test_overlap_cooldown();
    test_sof_overlap();
    test_negative_x();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rope_toggle_gen.md
ROPE_TOGGLE_GEN -- requirements
Module: rope_toggle_gen

Interface
REQ-001 SHALL have parameter LEFT_LIMIT, default 32: leftmost allowed rope topLeftX, in pixels.
REQ-002 SHALL have parameter RIGHT_LIMIT, default 608: rightmost allowed rope right edge, in pixels.
REQ-003 SHALL have parameter ROPE_WIDTH, default 16: rope width in pixels.
REQ-004 SHALL have parameter COOLDOWN_FRAMES, default 4: frames ignored after each toggle (range 0..15).
REQ-005 SHALL have port clk, input, 1: system clock.
REQ-006 SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port startOfFrame, input, 1: one-clk pulse at each frame start.
REQ-008 SHALL have port ropeDrawingRequest, input, 1: the rope pixel is active at the current scan pixel.
REQ-009 SHALL have port boundaryDrawingRequest, input, 1: a wall or obstacle pixel is active at the current scan pixel.
REQ-010 SHALL have port topLeftX, input, 11 signed: current rope X position, from the rope mover.
REQ-011 SHALL have port dirToggle, output, 1: one-clk request to reverse the rope direction.
REQ-012 SHALL have port movingRight, output, 1: tracked rope direction.
REQ-013 SHALL have port toggleCount, output, 8: number of toggles issued, saturating.

Function
REQ-014 SHALL implement FSM states ARMED, FIRE and COOLDOWN.
REQ-015 SHALL set hitLatch in any cycle where ropeDrawingRequest && boundaryDrawingRequest && !startOfFrame.
REQ-016 SHALL clear hitLatch in every startOfFrame cycle; overlap in that same cycle is discarded (it belongs to no frame).
REQ-017 SHALL compute posHit combinationally as (movingRight && topLeftX+ROPE_WIDTH >= RIGHT_LIMIT) || (!movingRight && topLeftX <= LEFT_LIMIT).
REQ-018 SHALL evaluate posHit with 12-bit signed arithmetic; a negative topLeftX SHALL satisfy the left condition.
REQ-019 In ARMED, on startOfFrame with (hitLatch || posHit), SHALL go to FIRE; otherwise it SHALL stay in ARMED.
REQ-020 In FIRE (exactly one clk), SHALL drive dirToggle=1, invert movingRight, and increment toggleCount, saturating at 255.
REQ-021 When leaving FIRE, SHALL load cdCnt=COOLDOWN_FRAMES and go to COOLDOWN; if COOLDOWN_FRAMES=0 it SHALL go directly to ARMED.
REQ-022 In COOLDOWN, on each startOfFrame SHALL decrement cdCnt; when the count reaches 0 it SHALL go to ARMED, in that same clk.
REQ-023 In COOLDOWN, SHALL ignore hitLatch and posHit.
REQ-024 SHALL drive dirToggle=1 only in FIRE, so dirToggle is high exactly one clk after the deciding startOfFrame. The mover clears its toggle guard on startOfFrame, so it accepts this pulse.
REQ-025 SHALL issue at most one dirToggle per frame.
REQ-026 Back-to-back startOfFrame pulses SHALL each be evaluated independently, per state.
REQ-027 Outputs SHALL be registered; no combinational path SHALL exist from inputs to dirToggle.

Reset
REQ-028 On resetN=0, SHALL asynchronously set state=ARMED, hitLatch=0, cdCnt=0, dirToggle=0, movingRight=1 and toggleCount=0.
REQ-029 A reset asserted mid-FIRE or mid-COOLDOWN SHALL abort it with no dirToggle pulse, and the block SHALL resume in ARMED once resetN=1.
REQ-030 The first evaluation after reset SHALL occur at the first startOfFrame seen with resetN=1.

Verification
REQ-031 Apply reset, topLeftX=280, no overlap, 10 frames -> dirToggle is never 1, movingRight=1, toggleCount=0.
REQ-032 Apply topLeftX=592, movingRight=1, then startOfFrame -> dirToggle=1 for exactly the next clk only, movingRight=0, toggleCount=1.
REQ-033 Assert overlap for 3 clk mid-frame, then startOfFrame -> one dirToggle pulse. Hold overlap for the next 4 frames -> no pulse. Overlap again in frame 6 -> second pulse at the frame-6 startOfFrame.
REQ-034 Assert overlap only in the same clk as startOfFrame -> no dirToggle at that frame or the next.
REQ-035 Apply topLeftX=-5, movingRight=0 -> toggle issued and movingRight=1. Apply topLeftX=-5, movingRight=1 -> no toggle.
REQ-036 Assert resetN=0 during FIRE -> dirToggle falls immediately and toggleCount=0. Force 300 toggles -> toggleCount holds at 255.
